// File: rtl/div_seq.sv
// Sequential 32-bit divider (signed/unsigned), restoring shift-subtract, one bit per cycle.
// Result is {remainder, quotient}; divide-by-zero yields zero without trapping.
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        annul_i,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [64:0] work;
   logic [31:0] divisor;
   logic        neg_q;
   logic        neg_r;

   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [33:0] trial;
   logic [64:0] stepped;
   logic [31:0] q_fin;
   logic [31:0] r_fin;

   // work[64] is always zero between steps, so a 34-bit trial difference captures the borrow.
   always_comb begin
      abs_a   = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      abs_b   = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
      trial   = work[64:31] - {2'b00, divisor};
      stepped = trial[33] ? {work[63:0], 1'b0} : {trial[32:0], work[30:0], 1'b1};
      q_fin   = neg_q ? (~stepped[31:0] + 32'd1) : stepped[31:0];
      r_fin   = neg_r ? (~stepped[63:32] + 32'd1) : stepped[63:32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         work     <= 65'd0;
         divisor  <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= 64'h0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i && !annul_i) begin
                  work    <= {33'd0, abs_a};
                  divisor <= abs_b;
                  neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                  neg_r   <= signed_div_i & opdata1_i[31];
                  cnt     <= 6'd0;
                  state   <= (opdata2_i == 32'd0) ? DIVZERO : RUN;
               end
            end
            DIVZERO: begin
               if (annul_i) begin
                  state <= IDLE;
               end else begin
                  result_o <= 64'h0;
                  state    <= DONE;
               end
            end
            RUN: begin
               if (annul_i) begin
                  state <= IDLE;
               end else begin
                  work <= stepped;
                  cnt  <= cnt + 6'd1;
                  // The 32nd step lands the sign-corrected result together with the move to DONE.
                  if (cnt == 6'd31) begin
                     result_o <= {r_fin, q_fin};
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               if (annul_i || !start_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready_o    = (state == DONE);
   assign stallreq_o = !rst && (((state == IDLE) && start_i && !annul_i) ||
                                (state == RUN) || (state == DIVZERO));

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes expected results, a negedge monitor checks them.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        annul;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   typedef struct {
      logic [63:0] res;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          compared = 0;
   int          failed = 0;
   int          cyc = 0;
   logic [63:0] last_exp = 64'h0;
   logic [63:0] held_exp = 64'h0;
   logic        ready_q = 1'b0;

   div_seq dut (
      .clk(clk),
      .rst(rst),
      .start_i(start),
      .annul_i(annul),
      .signed_div_i(signed_div),
      .opdata1_i(opdata1),
      .opdata2_i(opdata2),
      .result_o(result_o),
      .ready_o(ready_o),
      .stallreq_o(stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Arithmetic reference: divide magnitudes, then apply the sign rules.
   function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ma, mb, q, r;
      if (b == 32'd0) return 64'h0;
      ma = (sgn && a[31]) ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
      mb = (sgn && b[31]) ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
      q = ma / mb;
      r = ma % mb;
      if (sgn && (a[31] ^ b[31])) q = -q;
      if (sgn && a[31]) r = -r;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one divide, hold start until ready plus 'hold' extra cycles, then release.
   task automatic applyStimulus(input bit sync, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, input int hold);
      int   c;
      bit   got;
      exp_t e;
      if (sync) begin
         @(posedge clk);
         #1;
      end
      c          = cyc;
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      e.res      = refDiv(sgn, a, b);
      e.cyc      = c + ((b == 32'd0) ? 2 : 33);
      exp_q.push_back(e);
      last_exp   = e.res;
      #1 checkOutput("stall_issue", 64'(stallreq_o), 64'd1);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         #1;
         opdata1    = $urandom;
         opdata2    = $urandom;
         signed_div = 1'($urandom_range(0, 1));
         if (ready_o) got = 1'b1;
         else checkOutput("stall_busy", 64'(stallreq_o), 64'd1);
      end
      if (!got) begin
         compared++;
         failed++;
         $display("[TB] FAIL ready_timeout: ready_o stayed 0, expected 1 within 40 cycles");
      end else begin
         checkOutput("stall_done", 64'(stallreq_o), 64'd0);
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
         checkOutput("ready_hold", 64'(ready_o), 64'd1);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_drop", 64'(ready_o), 64'd0);
   endtask

   // Monitor: pop on every rising ready_o and check result, latency and stability while held.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ready_o && !ready_q) begin
         if (exp_q.size() == 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL spurious_ready: ready_o=1 with result %h, expected no completion", result_o);
         end else begin
            e = exp_q.pop_front();
            held_exp = e.res;
            checkOutput("result", result_o, e.res);
            checkOutput("latency", 64'(cyc), 64'(e.cyc));
         end
      end else if (!rst && ready_o && ready_q) begin
         checkOutput("result_stable", result_o, held_exp);
      end
      ready_q = ready_o;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          c;
      bit          sgn;
      int          sel;
      logic [31:0] a, b;

      rst        = 1'b1;
      start      = 1'b0;
      annul      = 1'b0;
      signed_div = 1'b0;
      opdata1    = 32'd0;
      opdata2    = 32'd0;
      #12;
      checkOutput("reset_ready", 64'(ready_o), 64'd0);
      checkOutput("reset_result", result_o, 64'h0);
      start = 1'b1;
      #1 checkOutput("reset_stall", 64'(stallreq_o), 64'd0);
      start = 1'b0;
      #9 rst = 1'b0;

      $display("[TB] directed cases");
      applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 0);
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2, 0);
      applyStimulus(1'b1, 1'b0, 32'd1234, 32'd0, 0);

      // Annul in the middle of a run: no completion, result untouched.
      @(posedge clk);
      #1;
      signed_div = 1'b0;
      opdata1    = 32'd5000;
      opdata2    = 32'd3;
      start      = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("annul_stall", 64'(stallreq_o), 64'd0);
      checkOutput("annul_ready", 64'(ready_o), 64'd0);
      checkOutput("annul_result", result_o, last_exp);
      annul = 1'b0;
      repeat (35) @(posedge clk);
      #1;
      checkOutput("annul_no_ready", 64'(ready_o), 64'd0);

      // Asynchronous reset mid-run, then a new op straight after release.
      @(posedge clk);
      #1;
      c          = cyc;
      signed_div = 1'b0;
      opdata1    = 32'd77777;
      opdata2    = 32'd13;
      start      = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_ready", 64'(ready_o), 64'd0);
      checkOutput("async_rst_stall", 64'(stallreq_o), 64'd0);
      checkOutput("async_rst_result", result_o, 64'h0);
      start = 1'b0;
      #1 rst = 1'b0;
      last_exp = 64'h0;
      applyStimulus(1'b0, 1'b0, 32'd9, 32'd3, 0);

      applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3);

      $display("[TB] random cases");
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         if (sel == 0) b = 32'd0;
         else if (sel < 4) b = $urandom_range(1, 15);
         else b = $urandom;
         if (sel == 9) begin
            sgn = 1'b1;
            a   = 32'h8000_0000;
            b   = 32'hFFFF_FFFF;
         end
         applyStimulus(1'b1, sgn, a, b, $urandom_range(0, 2));
      end

      repeat (4) @(posedge clk);
      #1;
      checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
